// File: rtl/ram_pkg.sv
// ram_pkg: shared parameter defaults and FSM encoding for ram_master.
package ram_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_LEN_W     = 4;
  localparam int unsigned DEF_RSP_DEPTH = 4;

  // Explicit values keep the legacy 2-bit state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_master_rsp_fifo.sv
// rsp_fifo: synchronous read-response buffer with full/empty flags and occupancy.
module rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags, guarded handshakes and head-of-queue data.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_master.sv
// ram_master: burst command front-end driving a registered single-port RAM,
// with a credit-limited read pipeline feeding an in-order response buffer.
module ram_master
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned LEN_W     = DEF_LEN_W,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              ram_enable,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              pins_last;
  logic              rd_wait;
  logic              wait_last;

  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_issue;
  logic              rd_pop;
  logic              rd_pins;
  logic              last_beat;
  logic [31:0]       occupancy;

  logic [DATA_W:0]   head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Handshakes, read credit check and output decode.
  always_comb begin
    cmd_ready = (state == IDLE);
    wr_ready  = (state == WRITE);
    cmd_fire  = cmd_valid && cmd_ready;
    wr_fire   = wr_valid && wr_ready;
    last_beat = (remaining == '0);
    rd_pins   = ram_enable && !ram_write_en;
    rd_valid  = !fifo_empty;
    rd_pop    = rd_valid && rd_ready;
    rd_data   = rd_valid ? head[DATA_W-1:0] : '0;
    rd_last   = rd_valid && head[DATA_W];
    // Reads on the pins and in the RAM's output register already own a
    // buffer slot; a beat leaving this cycle frees one.
    occupancy = 32'(fifo_count) + 32'(rd_pins) + 32'(rd_wait);
    rd_issue  = (state == READ) && ((occupancy - 32'(rd_pop)) < 32'(RSP_DEPTH));
    busy      = (state != IDLE) || rd_pins || rd_wait || !fifo_empty;
  end

  // Burst FSM: latches the command, walks the address and counts beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr  <= cmd_addr;
            remaining <= cmd_len;
            state     <= cmd_write ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (wr_fire || rd_issue) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (last_beat) state <= IDLE;
            else           remaining <= remaining - LEN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered RAM pins; address and write data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_enable   <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      pins_last    <= 1'b0;
    end else begin
      ram_enable   <= wr_fire || rd_issue;
      ram_write_en <= wr_fire;
      pins_last    <= rd_issue && last_beat;
      if (wr_fire || rd_issue) ram_addr  <= cur_addr;
      if (wr_fire)             ram_wdata <= wr_data;
    end
  end

  // Marks the cycle the RAM output register holds valid read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wait   <= 1'b0;
      wait_last <= 1'b0;
    end else begin
      rd_wait   <= rd_pins;
      wait_last <= rd_pins && pins_last;
    end
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_wait),
    .push_data ({wait_last, ram_rdata}),
    .pop       (rd_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The credit check guarantees a free slot for every returning read.
  rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_wait && fifo_full));

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master: randomized self-checking bench with a RAM model and an
// address-level reference model (shadow memory plus expected-beat queue).
module tb_ram_master;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          ram_enable;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  ram_master #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .LEN_W     (LW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .ram_enable   (ram_enable),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int unsigned a);
    return 16'((a * 32'd40503) ^ 32'h5A5A);
  endfunction

  // Registered-read RAM; random junk stands in for the floating bus when idle.
  logic [15:0] ram_mem [256];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (ram_enable && ram_write_en) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    if (ram_init && ram_enable && !ram_write_en) ram_rdata <= ram_mem[ram_addr];
    else ram_rdata <= 16'($urandom);
  end

  // Reference model
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic [15:0] shadow [256];
  beat_t       exp_q [$];
  int unsigned pop_cycles [$];
  logic [15:0] wdat [16];
  int          checks = 0;
  int          errors = 0;

  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] len,
                          output int unsigned hs_cyc);
    logic seen;
    seen = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = len;
    for (int i = 0; i < 100 && !seen; i++) begin
      seen = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    hs_cyc = cyc;
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: got cmd_ready=0 for 100 cycles, want 1 (addr %h)", a);
    end
  endtask

  task automatic queue_read(input logic [7:0] a, input logic [3:0] len);
    logic [7:0] ad;
    beat_t      e;
    ad = a;
    for (int unsigned i = 0; i <= 32'(len); i++) begin
      e.data = shadow[ad];
      e.last = (i == 32'(len));
      exp_q.push_back(e);
      ad = ad + 8'd1;
    end
  endtask

  // mode 0: no gaps, 1: wr_valid low every other cycle, 2: random gaps
  task automatic write_burst(input logic [7:0] a, input logic [3:0] len, input int unsigned mode);
    int unsigned left, idx;
    logic        prev_acc, v;
    logic [7:0]  prev_addr, ad;
    logic [15:0] prev_data;
    left = 32'(len) + 1; idx = 0; prev_acc = 1'b0; prev_addr = '0; prev_data = '0; ad = a;
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (prev_acc) begin
        if ({ram_enable, ram_write_en, ram_addr, ram_wdata} !== {1'b1, 1'b1, prev_addr, prev_data}) begin
          errors++;
          $display("FAIL wr_pins: got en=%0b we=%0b addr=%h data=%h, want en=1 we=1 addr=%h data=%h",
                   ram_enable, ram_write_en, ram_addr, ram_wdata, prev_addr, prev_data);
        end
      end else if (ram_enable !== 1'b0) begin
        errors++;
        $display("FAIL wr_gap: got ram_enable=%0b, want 0", ram_enable);
      end
      checks++;
      if (wr_ready !== (left > 0)) begin
        errors++;
        $display("FAIL wr_ready: got %0b, want %0b (beats left %0d)", wr_ready, left > 0, left);
      end
      if (left == 0 && !prev_acc) break;
      case (mode)
        0:       v = 1'b1;
        1:       v = (i % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      v = v && (left > 0);
      wr_valid = v;
      wr_data  = v ? wdat[idx] : 16'($urandom);
      prev_acc = v;
      if (v) begin
        prev_addr  = ad;
        prev_data  = wdat[idx];
        shadow[ad] = wdat[idx];
        ad = ad + 8'd1;
        idx++;
        left--;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic consume(input int unsigned n, input int unsigned pct);
    int unsigned got;
    beat_t       e;
    got = 0;
    for (int unsigned i = 0; i < n * 8 + 600 && got < n; i++) begin
      rd_ready = ($urandom_range(1, 100) <= pct);
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra: got beat data=%h, want no beat", rd_data);
        end else if (rd_ready) begin
          e = exp_q.pop_front();
          checks++;
          if ({rd_data, rd_last} !== {e.data, e.last}) begin
            errors++;
            $display("FAIL rd_beat: got data=%h last=%0b, want data=%h last=%0b",
                     rd_data, rd_last, e.data, e.last);
          end
          got++;
          pop_cycles.push_back(cyc + 1);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL rd_count: got %0d beats, want %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, busy, ram_enable, ram_write_en} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_flags: got %b, want 1000000",
               {cmd_ready, wr_ready, rd_valid, rd_last, busy, ram_enable, ram_write_en});
    end
    checks++;
    if ({rd_data, ram_addr, ram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rd_data=%h ram_addr=%h ram_wdata=%h, want 0",
               rd_data, ram_addr, ram_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int unsigned hs;
    beat_t       e;
    wdat[0] = 16'hA5A5;
    send_cmd(1'b1, 8'h10, 4'd0, hs);
    write_burst(8'h10, 4'd0, 0);
    rd_ready = 1'b1;
    send_cmd(1'b0, 8'h10, 4'd0, hs);
    queue_read(8'h10, 4'd0);
    for (int k = 0; k <= 3; k++) begin
      checks++;
      if (rd_valid !== (k == 3)) begin
        errors++;
        $display("FAIL rd_latency: cycle %0d after handshake got rd_valid=%0b, want %0b", k, rd_valid, k == 3);
      end
      if (k == 3 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rd_data, rd_last} !== {16'hA5A5, 1'b1}) begin
          errors++;
          $display("FAIL basic_data: got data=%h last=%0b, want data=a5a5 last=1", rd_data, rd_last);
        end
      end
      if (k < 3) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if ({rd_valid, busy, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL basic_idle: got valid/busy/ready=%b, want 001", {rd_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_wrap();
    int unsigned hs;
    for (int i = 0; i < 4; i++) wdat[i] = 16'(i + 1);
    send_cmd(1'b1, 8'hFE, 4'd3, hs);
    write_burst(8'hFE, 4'd3, 0);
    send_cmd(1'b0, 8'hFE, 4'd3, hs);
    queue_read(8'hFE, 4'd3);
    consume(4, 100);
  endtask

  task automatic test_throughput();
    int unsigned hs;
    logic [7:0]  a;
    beat_t       e;
    a = 8'($urandom);
    rd_ready = 1'b1;
    send_cmd(1'b0, a, 4'd7, hs);
    queue_read(a, 4'd7);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (rd_valid !== (k >= 3 && k <= 10)) begin
        errors++;
        $display("FAIL rd_stream: cycle %0d got rd_valid=%0b, want %0b", k, rd_valid, k >= 3 && k <= 10);
      end
      if (rd_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rd_data, rd_last} !== {e.data, e.last}) begin
          errors++;
          $display("FAIL stream_beat: got data=%h last=%0b, want data=%h last=%0b",
                   rd_data, rd_last, e.data, e.last);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int unsigned hs, issues;
    logic [7:0]  a;
    a = 8'($urandom);
    rd_ready = 1'b0;
    send_cmd(1'b0, a, 4'd15, hs);
    queue_read(a, 4'd15);
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      if (ram_enable && !ram_write_en) issues++;
      @(negedge clk);
    end
    checks++;
    if (issues != DEPTH) begin
      errors++;
      $display("FAIL rd_credit: got %0d reads issued while stalled, want %0d", issues, DEPTH);
    end
    checks++;
    if ({cmd_ready, busy, rd_valid} !== 3'b011) begin
      errors++;
      $display("FAIL stall_state: got ready/busy/valid=%b, want 011", {cmd_ready, busy, rd_valid});
    end
    consume(16, 100);
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL drain_idle: got ready/busy=%b, want 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_gappy_write();
    int unsigned hs;
    logic [7:0]  a;
    a = 8'($urandom);
    for (int i = 0; i < 8; i++) wdat[i] = 16'($urandom);
    send_cmd(1'b1, a, 4'd7, hs);
    write_burst(a, 4'd7, 1);
    send_cmd(1'b0, a, 4'd7, hs);
    queue_read(a, 4'd7);
    consume(8, 50);
  endtask

  task automatic test_back_to_back();
    int unsigned h1, h2;
    logic [7:0]  a, b;
    a = 8'($urandom); b = 8'($urandom);
    pop_cycles.delete();
    fork
      consume(4, 100);
      begin
        send_cmd(1'b0, a, 4'd1, h1);
        queue_read(a, 4'd1);
        send_cmd(1'b0, b, 4'd1, h2);
        queue_read(b, 4'd1);
      end
    join
    checks++;
    if (pop_cycles.size() != 4 || !(h2 < pop_cycles[1])) begin
      errors++;
      $display("FAIL b2b_overlap: got second handshake cycle %0d, want before first burst drains (%0d beats)",
               h2, pop_cycles.size());
    end
  endtask

  task automatic test_reset_mid();
    int unsigned hs, issues, bad;
    logic [7:0]  a;
    beat_t       e;
    a = 8'($urandom);
    rd_ready = 1'b1;
    send_cmd(1'b0, a, 4'd15, hs);
    queue_read(a, 4'd15);
    issues = 0;
    for (int k = 0; k < 40 && issues < 5; k++) begin
      if (rd_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rd_data, rd_last} !== {e.data, e.last}) begin
          errors++;
          $display("FAIL pre_reset_beat: got data=%h last=%0b, want data=%h last=%0b",
                   rd_data, rd_last, e.data, e.last);
        end
      end
      if (ram_enable && !ram_write_en) issues++;
      if (issues < 5) @(negedge clk);
    end
    checks++;
    if (issues != 5) begin
      errors++;
      $display("FAIL mid_issue: got %0d reads issued, want 5", issues);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_enable, rd_valid, busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset: got en/valid/busy/ready=%b, want 0001",
               {ram_enable, rd_valid, busy, cmd_ready});
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (ram_enable !== 1'b0 || rd_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d cycles with RAM access or rd_valid, want 0", bad);
    end
  endtask

  task automatic test_random();
    logic        cw [12];
    logic [7:0]  ca [12];
    logic [3:0]  cl [12];
    int unsigned total;
    total = 0;
    for (int i = 0; i < 12; i++) begin
      cw[i] = 1'($urandom_range(0, 1));
      ca[i] = 8'($urandom);
      cl[i] = 4'($urandom_range(0, 15));
      if (!cw[i]) total += 32'(cl[i]) + 1;
    end
    fork
      consume(total, 60);
      begin
        int unsigned hs;
        for (int i = 0; i < 12; i++) begin
          if (cw[i]) begin
            for (int j = 0; j < 16; j++) wdat[j] = 16'($urandom);
            send_cmd(1'b1, ca[i], cl[i], hs);
            write_burst(ca[i], cl[i], 2);
          end else begin
            send_cmd(1'b0, ca[i], cl[i], hs);
            queue_read(ca[i], cl[i]);
          end
        end
      end
    join
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    test_reset();
    test_basic();
    test_wrap();
    test_throughput();
    test_backpressure();
    test_gappy_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
